// File: rtl/morse_symbol_classifier.sv
// morse_symbol_classifier
//   Samples a raw Morse key on ticks derived from the clock divider output,
//   debounces it, times each press and release in ticks, classifies each
//   press as dot or dash, and hands the packed letter code downstream over
//   a valid/ready handshake once the inter-letter gap expires.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   div_clk    divider output; every level change is one tick
//   key_in     raw asynchronous Morse key, 1 = pressed
//   code_ready downstream accepts code
//   code_out   symbol bits, bit0 = first symbol, 1 = dash, 0 = dot
//   code_len   number of valid symbols in code_out
//   code_valid letter code available
//   overflow   more than MAX_SYMS symbols keyed in the current letter
//   key_clean  debounced key level
module morse_symbol_classifier #(
   parameter int unsigned DEBOUNCE_N = 3,
   parameter int unsigned DASH_TICKS = 6,
   parameter int unsigned LETTER_GAP = 8,
   parameter int unsigned MAX_SYMS   = 5,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                div_clk,
   input  logic                key_in,
   input  logic                code_ready,
   output logic [MAX_SYMS-1:0] code_out,
   output logic [2:0]          code_len,
   output logic                code_valid,
   output logic                overflow,
   output logic                key_clean
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_N + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_N - 1);
   localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(DASH_TICKS);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LETTER_GAP - 1);
   localparam logic [2:0]       LEN_MAX  = 3'(MAX_SYMS);

   typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

   state_t state, state_nxt;

   logic key_s1, key_s2;
   logic div_s1, div_s2, div_prev;
   logic tick;
   logic [DB_W-1:0] db_cnt;
   logic key_prev;
   logic rise, fall;
   logic [CNT_W-1:0] press_cnt;
   logic [CNT_W-1:0] gap_cnt;
   logic gap_done;
   logic handshake;
   logic sym;

   // Two-flop synchronizers; div_prev holds the previous synced divider level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_s1   <= 1'b0;
         key_s2   <= 1'b0;
         div_s1   <= 1'b0;
         div_s2   <= 1'b0;
         div_prev <= 1'b0;
      end else begin
         key_s1   <= key_in;
         key_s2   <= key_s1;
         div_s1   <= div_clk;
         div_s2   <= div_s1;
         div_prev <= div_s2;
      end
   end

   assign tick = div_s2 ^ div_prev;

   // db_cnt counts consecutive disagreeing tick samples; the DEBOUNCE_N-th
   // one flips key_clean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt    <= '0;
         key_clean <= 1'b0;
      end else if (tick) begin
         if (key_s2 != key_clean) begin
            if (db_cnt == DB_LAST) begin
               key_clean <= ~key_clean;
               db_cnt    <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) key_prev <= 1'b0;
      else     key_prev <= key_clean;
   end

   assign rise      = key_clean & ~key_prev;
   assign fall      = ~key_clean & key_prev;
   assign gap_done  = tick && (gap_cnt == GAP_LAST);
   assign handshake = (state == EMIT) && code_ready;
   assign sym       = (press_cnt >= DASH_MIN);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a rise beats the terminating gap tick.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (rise) state_nxt = PRESS;
         PRESS: if (fall) state_nxt = GAP;
         GAP: begin
            if (rise)          state_nxt = PRESS;
            else if (gap_done) state_nxt = EMIT;
         end
         EMIT:  if (handshake) state_nxt = key_clean ? PRESS : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      code_valid = (state == EMIT);
   end

   // Counters and letter accumulation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         press_cnt <= '0;
         gap_cnt   <= '0;
         code_out  <= '0;
         code_len  <= '0;
         overflow  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (rise) press_cnt <= '0;
            end
            PRESS: begin
               if (fall) begin
                  if (code_len < LEN_MAX) begin
                     code_out[code_len] <= sym;
                     code_len           <= code_len + 3'd1;
                  end else begin
                     overflow <= 1'b1;
                  end
                  gap_cnt <= '0;
               end else if (tick && (press_cnt != '1)) begin
                  press_cnt <= press_cnt + 1'b1;
               end
            end
            GAP: begin
               if (rise)      press_cnt <= '0;
               else if (tick) gap_cnt   <= gap_cnt + 1'b1;
            end
            EMIT: begin
               if (handshake) begin
                  code_out  <= '0;
                  code_len  <= '0;
                  overflow  <= 1'b0;
                  press_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// tb_morse_symbol_classifier
//   Directed bench for morse_symbol_classifier: a table of letters keyed with
//   fixed dot/dash/gap durations, plus hand sequences for bounce, isolated
//   glitch, backpressure, reset mid-press and press-counter saturation.
//   div_clk toggles every 4 clk, so one tick is 4 clk. Stimulus is aligned to
//   the clk edge at which the DUT captures a fresh divider level, so a key
//   level held for 4*N clk yields exactly N debounce samples.
module tb_morse_symbol_classifier;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       div_clk = 1'b0;
   logic       key_in = 1'b0;
   logic       code_ready = 1'b0;
   logic [4:0] code_out;
   logic [2:0] code_len;
   logic       code_valid;
   logic       overflow;
   logic       key_clean;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned ph = 0;

   morse_symbol_classifier #(
      .DEBOUNCE_N(3),
      .DASH_TICKS(6),
      .LETTER_GAP(8),
      .MAX_SYMS  (5),
      .CNT_W     (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .div_clk   (div_clk),
      .key_in    (key_in),
      .code_ready(code_ready),
      .code_out  (code_out),
      .code_len  (code_len),
      .code_valid(code_valid),
      .overflow  (overflow),
      .key_clean (key_clean)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      ph = (ph + 1) % 4;
      if (ph == 0) div_clk = ~div_clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      int unsigned nsym;
      logic [7:0]  mask;
      logic [4:0]  exp_code;
      logic [2:0]  exp_len;
      logic        exp_ovf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Return #1 after the posedge that captures a new divider level.
   task automatic align();
      @(posedge clk);
      while (ph != 0) @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic v, input int unsigned ticks);
      key_in = v;
      repeat (4 * ticks) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int unsigned budget, output bit seen);
      seen = 1'b0;
      for (int unsigned i = 0; i < budget; i++) begin
         if (code_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic key_letter(input int unsigned n, input logic [7:0] mask);
      align();
      for (int unsigned i = 0; i < n; i++) begin
         hold(1'b1, mask[i] ? 10 : 4);
         hold(1'b0, 3);
      end
   endtask

   task automatic do_handshake(input string tag);
      code_ready = 1'b1;
      @(posedge clk);
      #1;
      code_ready = 1'b0;
      chk({tag, "_hs_valid"}, code_valid, 1'b0);
      chk({tag, "_hs_len"},   code_len,   3'd0);
      chk({tag, "_hs_code"},  code_out,   5'd0);
      chk({tag, "_hs_ovf"},   overflow,   1'b0);
   endtask

   task automatic expect_letter(input string tag, input logic [4:0] c, input logic [2:0] l, input logic o);
      bit seen;
      wait_valid(400, seen);
      chk({tag, "_valid"}, seen, 1'b1);
      chk({tag, "_code"}, code_out, c);
      chk({tag, "_len"},  code_len, l);
      chk({tag, "_ovf"},  overflow, o);
   endtask

   initial begin
      vec_t vecs[7];
      bit   seen_a, seen_b, stable;

      vecs[0] = '{nsym: 2, mask: 8'b0000_0010, exp_code: 5'b00010, exp_len: 3'd2, exp_ovf: 1'b0}; // A .-
      vecs[1] = '{nsym: 1, mask: 8'b0000_0000, exp_code: 5'b00000, exp_len: 3'd1, exp_ovf: 1'b0}; // E .
      vecs[2] = '{nsym: 1, mask: 8'b0000_0001, exp_code: 5'b00001, exp_len: 3'd1, exp_ovf: 1'b0}; // T -
      vecs[3] = '{nsym: 3, mask: 8'b0000_0101, exp_code: 5'b00101, exp_len: 3'd3, exp_ovf: 1'b0}; // K -.-
      vecs[4] = '{nsym: 5, mask: 8'b0001_1111, exp_code: 5'b11111, exp_len: 3'd5, exp_ovf: 1'b0}; // 0 -----
      vecs[5] = '{nsym: 6, mask: 8'b0000_0000, exp_code: 5'b00000, exp_len: 3'd5, exp_ovf: 1'b1}; // six dots
      vecs[6] = '{nsym: 6, mask: 8'b0010_0101, exp_code: 5'b00101, exp_len: 3'd5, exp_ovf: 1'b1}; // sixth dash dropped

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", code_valid, 1'b0);
      chk("rst_code",  code_out,   5'd0);
      chk("rst_len",   code_len,   3'd0);
      chk("rst_ovf",   overflow,   1'b0);
      chk("rst_clean", key_clean,  1'b0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Table of letters
      for (int unsigned v = 0; v < 7; v++) begin
         key_letter(vecs[v].nsym, vecs[v].mask);
         expect_letter($sformatf("vec%0d", v), vecs[v].exp_code, vecs[v].exp_len, vecs[v].exp_ovf);
         do_handshake($sformatf("vec%0d", v));
      end

      // Bounce: per-clk toggling whose tick samples land on 0, then a clean dot
      align();
      for (int unsigned j = 0; j < 8; j++) begin
         key_in = (j % 2 == 0);
         @(posedge clk);
         #1;
      end
      hold(1'b1, 4);
      hold(1'b0, 3);
      expect_letter("bounce", 5'b00000, 3'd1, 1'b0);
      do_handshake("bounce");

      // Isolated one-tick pulse never reaches key_clean
      align();
      hold(1'b1, 1);
      key_in = 1'b0;
      seen_a = 1'b0;
      seen_b = 1'b0;
      for (int unsigned i = 0; i < 120; i++) begin
         @(posedge clk);
         #1;
         if (key_clean)  seen_a = 1'b1;
         if (code_valid) seen_b = 1'b1;
      end
      chk("glitch_clean", seen_a, 1'b0);
      chk("glitch_valid", seen_b, 1'b0);

      // Backpressure: letter "-." held in EMIT while key is pressed
      key_letter(2, 8'b0000_0001);
      expect_letter("bp", 5'b00001, 3'd2, 1'b0);
      align();
      key_in = 1'b1;
      stable = 1'b1;
      for (int unsigned i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (code_valid !== 1'b1 || code_out !== 5'b00001 || code_len !== 3'd2 || overflow !== 1'b0)
            stable = 1'b0;
      end
      chk("bp_stable", stable, 1'b1);
      chk("bp_clean",  key_clean, 1'b1);
      code_ready = 1'b1;
      @(posedge clk);
      #1;
      code_ready = 1'b0;
      key_in = 1'b0;
      chk("bp_hs_valid", code_valid, 1'b0);
      chk("bp_hs_len",   code_len,   3'd0);
      // Handshake with key held lands in PRESS, so the release yields a dot
      expect_letter("bp_press", 5'b00000, 3'd1, 1'b0);
      do_handshake("bp_press");

      // Reset mid-press
      align();
      hold(1'b1, 5);
      rst = 1'b1;
      #1;
      chk("mrst_valid", code_valid, 1'b0);
      chk("mrst_code",  code_out,   5'd0);
      chk("mrst_len",   code_len,   3'd0);
      chk("mrst_ovf",   overflow,   1'b0);
      chk("mrst_clean", key_clean,  1'b0);
      key_in = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      seen_a = 1'b0;
      seen_b = 1'b0;
      for (int unsigned i = 0; i < 160; i++) begin
         @(posedge clk);
         #1;
         if (key_clean)  seen_a = 1'b1;
         if (code_valid) seen_b = 1'b1;
      end
      chk("mrst_after_clean", seen_a, 1'b0);
      chk("mrst_after_valid", seen_b, 1'b0);

      // Saturation of the press counter
      align();
      hold(1'b1, 300);
      chk("sat_press_cnt", dut.press_cnt, 8'd255);
      key_in = 1'b0;
      expect_letter("sat", 5'b00001, 3'd1, 1'b0);
      do_handshake("sat");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/morse_symbol_classifier.md
Name: morse_symbol_classifier

Overview:
- Sits directly downstream of the clock divider in the Morse decipher path.
- Uses the divider's toggling output as its sample timebase.
- Debounces the raw Morse key, measures press and release durations in ticks, and classifies each press as dot or dash.
- Packs up to MAX_SYMS symbols into a letter code and presents it to the letter decoder over a valid/ready handshake once the inter-letter gap expires.

Parameters:
DEBOUNCE_N, 3, consecutive agreeing tick samples required to change key_clean
DASH_TICKS, 6, press length in ticks at or above which a press is a dash
LETTER_GAP, 8, release length in ticks that terminates a letter
MAX_SYMS, 5, max symbols per letter (must be ≤7)
CNT_W, 8, width of press/gap tick counters

Ports:
clk  in  1  system clock
rst  in  1  reset
div_clk  in  1  divider output; every level change is one tick
key_in  in  1  raw asynchronous Morse key, 1 = pressed
code_ready  in  1  downstream accepts code
code_out  out  MAX_SYMS  symbol bits; bit0 = first symbol; 1 = dash, 0 = dot
code_len  out  3  number of valid symbols in code_out
code_valid  out  1  letter code available
overflow  out  1  more than MAX_SYMS symbols were keyed in the current letter
key_clean  out  1  debounced key level

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- On reset: all outputs 0, state IDLE, all counters 0, synchronizer flops 0.
- Synchronization: key_in and div_clk each pass through 2 flops.
- Tick generation: tick = 1-cycle pulse when the synced div_clk differs from its previous registered value.
- Debounce (evaluated only on tick):
  - If synced key ≠ key_clean, increment db_cnt; otherwise clear db_cnt.
  - When db_cnt reaches DEBOUNCE_N-1 and the current sample also disagrees, toggle key_clean and clear db_cnt.
  - A glitch shorter than DEBOUNCE_N ticks never changes key_clean.
- Edge detection: rise and fall are 1-cycle pulses derived from key_clean versus its registered copy.
- IDLE: code empty. On rise: press_cnt = 0, go to PRESS.
- PRESS: on each tick, press_cnt++, saturating at 2^CNT_W-1. On fall:
  - sym = (press_cnt ≥ DASH_TICKS).
  - If code_len < MAX_SYMS: code_out[code_len] = sym, code_len++.
  - Else: symbol dropped, overflow = 1 (sticky).
  - Then gap_cnt = 0, go to GAP.
- GAP: on each tick, gap_cnt++.
  - On rise: press_cnt = 0, go to PRESS.
  - When gap_cnt reaches LETTER_GAP: go to EMIT, code_valid = 1 on the following cycle.
  - If rise and the terminating tick occur in the same cycle, the rise wins.
- EMIT:
  - code_valid held at 1; code_out, code_len and overflow held stable until handshake.
  - key_clean edges are ignored while in EMIT; debounce keeps running.
  - On code_valid & code_ready: on the next edge, code_out, code_len, overflow and code_valid are cleared.
  - Next state is PRESS (press_cnt = 0) if key_clean = 1, else IDLE.
- Unused code_out bits above code_len are 0.
- Latency: key_in change to key_clean change is 2 clk + DEBOUNCE_N ticks (±1 tick sampling phase). Terminating tick to code_valid is 1 clk.
- Reset mid-operation (any state): immediate return to the reset values above. A pending press is discarded; no symbol results from the subsequent release, because key_clean restarts at 0 and must re-debounce.
- div_clk static: no ticks occur, so the FSM and debounce freeze in place; the handshake still completes in EMIT.

Test Plan (bench toggles div_clk every 4 clk, i.e. one tick per 4 clk; default parameters):
1. Letter "A": key high 4 ticks, low 3 ticks, high 10 ticks, then low → code_valid after ~11 low ticks with code_out=5'b00010, code_len=2, overflow=0.
2. Bounce/glitch: key toggling every clk for 2 ticks, then high 4 ticks, then low → exactly one dot (code_len=1, code_out=0). An isolated 1-tick high pulse → key_clean stays 0, no code_valid.
3. Overflow: six dots (4 high / 3 low ticks each), then gap → code_len=5, code_out=5'b00000, overflow=1; after handshake overflow=0.
4. Backpressure: code_ready held 0 for 40 clk in EMIT, with the key pressed meanwhile → code_valid, code_out and code_len constant throughout. Ready pulse → code_valid=0 next clk, code_len=0, state PRESS because key_clean=1.
5. Reset mid-press: rst asserted after key held 5 ticks → all outputs 0 immediately; releasing key after rst drops → no symbol, no code_valid.
6. Saturation: key held 300 ticks (CNT_W=8) → press_cnt stops at 255, symbol classified as dash, code_out=5'b00001, code_len=1.
